// File: rtl/assembly_check_monitor_pkg.sv
// Shared parameters for the assembly check monitor: state encoding,
// default widths/limits and small saturating-counter helpers.
package assembly_check_monitor_pkg;

  localparam int XLEN_DEFAULT                = 32;
  localparam int PROGRAM_MEMORY_SIZE_DEFAULT = 100;
  localparam int NUM_REGS                    = 32;
  localparam int REG_IDX_W                   = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  function automatic logic [31:0] satInc32(input logic [31:0] value, input logic en);
    return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] value, input logic en);
    return (en && (value != 16'hFFFF)) ? value + 16'd1 : value;
  endfunction

endpackage

// File: rtl/assembly_check_monitor_check_reg_scan.sv
// Lowest-set-bit search: reports the smallest index whose bit is set and
// whether any bit is set at all.
module check_reg_scan #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_index,
  output logic             o_any
);

  // Walk from the top down so the last hit written is the lowest index.
  always_comb begin
    o_index = '0;
    o_any   = |i_vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/assembly_check_monitor.sv
// Assembly check monitor: watches register writebacks from a core running a
// self-checking program and reports pass, fail (a check register went
// nonzero) or timeout, along with retire/cycle statistics.
module assembly_check_monitor
  import assembly_check_monitor_pkg::*;
#(
  parameter int          XLEN                = XLEN_DEFAULT,
  parameter logic [31:0] CHECK_MASK          = 32'h8000_0000,
  parameter int          TEST_REG            = 1,
  parameter int          PROGRAM_MEMORY_SIZE = PROGRAM_MEMORY_SIZE_DEFAULT,
  parameter int          MAX_CYCLES          = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 retire,
  input  logic                 instr_valid,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [REG_IDX_W-1:0] fail_reg,
  output logic [XLEN-1:0]      fail_test,
  output logic [XLEN-1:0]      current_test,
  output logic [15:0]          test_changes,
  output logic [31:0]          retired,
  output logic [31:0]          cycles
);

  // x0 is hardwired to zero, so it is never watched or shadowed.
  localparam logic [REG_IDX_W-1:0] TEST_IDX    = REG_IDX_W'(TEST_REG);
  localparam logic [31:0]          WATCH_MASK  = CHECK_MASK & ~32'd1;
  localparam logic [31:0]          TRACK_MASK  = (CHECK_MASK | (32'd1 << TEST_REG)) & ~32'd1;
  localparam logic [32:0]          RETIRE_LIM  = 33'(PROGRAM_MEMORY_SIZE);
  localparam logic [31:0]          CYCLE_LIM   = 32'(MAX_CYCLES - 1);

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic                   r_fail;
  logic                   r_timeout;
  logic [REG_IDX_W-1:0]   r_failReg;
  logic [XLEN-1:0]        r_failTest;
  logic [15:0]            r_testChanges;
  logic [31:0]            r_retired;
  logic [31:0]            r_cycles;
  logic [XLEN-1:0]        r_shadow [NUM_REGS];

  logic [XLEN-1:0]        w_bypass [NUM_REGS];
  logic [NUM_REGS-1:0]    w_nonzero;
  logic [REG_IDX_W-1:0]   w_scanIdx;
  logic                   w_anyFail;
  logic                   w_arm;
  logic                   w_testWr;
  logic                   w_testChange;
  logic [XLEN-1:0]        w_failTest;
  logic [31:0]            w_cyclesNext;
  logic                   w_passHit;
  logic                   w_timeoutHit;

  // Overlay this cycle's write on the shadows so a violation is caught on
  // the edge of the offending write rather than one cycle later.
  always_comb begin
    w_nonzero = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_bypass[i] = (wb_valid && (wb_rd == REG_IDX_W'(i)) && TRACK_MASK[i]) ? wb_data : r_shadow[i];
      w_nonzero[i] = WATCH_MASK[i] && (w_bypass[i] != '0);
    end
  end

  check_reg_scan #(
    .WIDTH (NUM_REGS),
    .IDX_W (REG_IDX_W)
  ) u_scan (
    .i_vec   (w_nonzero),
    .o_index (w_scanIdx),
    .o_any   (w_anyFail)
  );

  // Sub-test tracking and exit conditions evaluated for the current RUN cycle.
  always_comb begin
    w_arm        = start && (r_state != RUN);
    w_testWr     = wb_valid && (wb_rd == TEST_IDX) && (TEST_IDX != '0);
    w_testChange = w_testWr && (wb_data != r_shadow[TEST_IDX]);
    w_failTest   = w_testWr ? wb_data : r_shadow[TEST_IDX];
    w_cyclesNext = satInc32(r_cycles, 1'b1);
    w_passHit    = !instr_valid || (({1'b0, r_retired} + 33'(retire)) >= RETIRE_LIM);
    w_timeoutHit = (w_cyclesNext >= CYCLE_LIM);
  end

  // Run-control FSM with registered status outputs; terminal states hold
  // everything frozen until a new start re-arms the monitor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_failReg     <= '0;
      r_failTest    <= '0;
      r_testChanges <= '0;
      r_retired     <= '0;
      r_cycles      <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_arm) begin
      r_state       <= RUN;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_failReg     <= '0;
      r_failTest    <= '0;
      r_testChanges <= '0;
      r_retired     <= '0;
      r_cycles      <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (r_state == RUN) begin
      r_retired     <= satInc32(r_retired, retire);
      r_cycles      <= w_cyclesNext;
      r_testChanges <= satInc16(r_testChanges, w_testChange);
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= w_bypass[i];
      end
      if (w_anyFail) begin
        r_state    <= FAIL;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_fail     <= 1'b1;
        r_failReg  <= w_scanIdx;
        r_failTest <= w_failTest;
      end else if (w_passHit) begin
        r_state <= PASS;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_pass  <= 1'b1;
      end else if (w_timeoutHit) begin
        r_state   <= TIMEOUT;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_timeout <= 1'b1;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign timeout      = r_timeout;
  assign fail_reg     = r_failReg;
  assign fail_test    = r_failTest;
  assign current_test = r_shadow[TEST_IDX];
  assign test_changes = r_testChanges;
  assign retired      = r_retired;
  assign cycles       = r_cycles;

endmodule

// File: tb/tb_assembly_check_monitor.sv
// Directed testbench for assembly_check_monitor: pass, fail, same-cycle
// priority, timeout, mid-run reset and a full-length program run.
module tb_assembly_check_monitor;

  logic        clk;
  logic        resetN;
  logic        start;
  logic        retire;
  logic        instrValid;
  logic        wbValid;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [4:0]  failReg;
  logic [31:0] failTest;
  logic [31:0] currentTest;
  logic [15:0] testChanges;
  logic [31:0] retired;
  logic [31:0] cycles;

  int checkCount = 0;
  int errorCount = 0;
  int waitCycles;

  assembly_check_monitor #(
    .XLEN                (32),
    .CHECK_MASK          (32'hC000_0000),
    .TEST_REG            (1),
    .PROGRAM_MEMORY_SIZE (100),
    .MAX_CYCLES          (120)
  ) dut (
    .clk          (clk),
    .reset        (resetN),
    .start        (start),
    .retire       (retire),
    .instr_valid  (instrValid),
    .wb_valid     (wbValid),
    .wb_rd        (wbRd),
    .wb_data      (wbData),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .fail_reg     (failReg),
    .fail_test    (failTest),
    .current_test (currentTest),
    .test_changes (testChanges),
    .retired      (retired),
    .cycles       (cycles)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iStart, input logic iRetire, input logic iInstrValid,
                               input logic iWbValid, input logic [4:0] iWbRd, input logic [31:0] iWbData);
    start      = iStart;
    retire     = iRetire;
    instrValid = iInstrValid;
    wbValid    = iWbValid;
    wbRd       = iWbRd;
    wbData     = iWbData;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN     = 1'b0;
    start      = 1'b0;
    retire     = 1'b0;
    instrValid = 1'b1;
    wbValid    = 1'b0;
    wbRd       = 5'd0;
    wbData     = 32'd0;
    #3;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_cycles", 64'(cycles), 64'd0);
    checkOutput("reset_current_test", 64'(currentTest), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    checkOutput("idle_no_start_busy", 64'(busy), 64'd0);

    // Five retires then an invalid fetch ends the run with pass.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    checkOutput("start_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    end
    checkOutput("run5_done", 64'(done), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("p1_pass", 64'(pass), 64'd1);
    checkOutput("p1_done", 64'(done), 64'd1);
    checkOutput("p1_fail", 64'(fail), 64'd0);
    checkOutput("p1_busy", 64'(busy), 64'd0);
    checkOutput("p1_retired", 64'(retired), 64'd5);
    checkOutput("p1_cycles", 64'(cycles), 64'd6);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    checkOutput("p1_frozen_retired", 64'(retired), 64'd5);
    checkOutput("p1_frozen_cycles", 64'(cycles), 64'd6);

    // Re-arm, set sub-test 3, ignore a start mid-run, then trip x31.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    checkOutput("rearm_pass_cleared", 64'(pass), 64'd0);
    checkOutput("rearm_retired_cleared", 64'(retired), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'd3);
    checkOutput("f1_current_test", 64'(currentTest), 64'd3);
    checkOutput("f1_test_changes", 64'(testChanges), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 32'd3);
    checkOutput("f1_start_ignored_retired", 64'(retired), 64'd2);
    checkOutput("f1_same_value_no_change", 64'(testChanges), 64'd1);
    checkOutput("f1_fail_before", 64'(fail), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 32'h4);
    checkOutput("f1_fail", 64'(fail), 64'd1);
    checkOutput("f1_pass", 64'(pass), 64'd0);
    checkOutput("f1_done", 64'(done), 64'd1);
    checkOutput("f1_fail_reg", 64'(failReg), 64'd31);
    checkOutput("f1_fail_test", 64'(failTest), 64'd3);
    checkOutput("f1_test_changes_final", 64'(testChanges), 64'd1);

    // Same-cycle x30 violation and end of program: fail wins.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    checkOutput("rearm2_fail_cleared", 64'(fail), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd30, 32'h1);
    checkOutput("prio_fail", 64'(fail), 64'd1);
    checkOutput("prio_pass", 64'(pass), 64'd0);
    checkOutput("prio_fail_reg", 64'(failReg), 64'd30);
    checkOutput("prio_fail_test", 64'(failTest), 64'd0);

    // No retires, fetch stays valid: cycle budget runs out.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    waitCycles = 0;
    for (int n = 1; n <= 200; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      waitCycles = n;
      if (done) break;
    end
    checkOutput("to_latency", 64'(waitCycles), 64'd119);
    checkOutput("to_timeout", 64'(timeout), 64'd1);
    checkOutput("to_pass", 64'(pass), 64'd0);
    checkOutput("to_cycles", 64'(cycles), 64'd119);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    checkOutput("to_cycles_frozen", 64'(cycles), 64'd119);

    // Reset in the middle of a run aborts it silently.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'd7);
    end
    checkOutput("pre_reset_retired", 64'(retired), 64'd6);
    resetN = 1'b0;
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_retired", 64'(retired), 64'd0);
    checkOutput("rst_cycles", 64'(cycles), 64'd0);
    checkOutput("rst_current_test", 64'(currentTest), 64'd0);
    checkOutput("rst_timeout", 64'(timeout), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("post_rst_idle_busy", 64'(busy), 64'd0);
    checkOutput("post_rst_idle_done", 64'(done), 64'd0);
    checkOutput("post_rst_idle_retired", 64'(retired), 64'd0);

    // Full-length program: 100 retires with a write to x0 along the way.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, (i == 0), 5'd0, 32'd5);
      if (i == 98) begin
        checkOutput("len_done_at_99", 64'(done), 64'd0);
      end
    end
    checkOutput("len_pass", 64'(pass), 64'd1);
    checkOutput("len_fail", 64'(fail), 64'd0);
    checkOutput("len_retired", 64'(retired), 64'd100);
    checkOutput("len_cycles", 64'(cycles), 64'd100);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
